bcd_multi_counter_ssd: RTL and testbench
========================================

Name: bcd_multi_counter_ssd

Overview:
- Parametrised successor to the single-digit 1 Hz BCD down-counter display.
- Holds a DIGITS-wide BCD counter with selectable up/down mode, synchronous parallel load and enable.
- Divides clk internally into a count tick and a display-scan tick.
- Time-multiplexes all digits onto one active-low seven-segment bus and one active-low digit-select bus.

Parameters:
- DIGITS, 4, number of BCD digits (legal range 1..4).
- TICK_DIV, 100000000, clk cycles per count step (>=2).
- SCAN_DIV, 100000, clk cycles each digit stays selected (>=1).
- CNT_W, 30, width of the internal tick and scan divider counters; must hold TICK_DIV-1 and SCAN_DIV-1.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  1 = divider runs and counter counts; 0 = count and tick divider hold.
- up_dn  input  1  1 = count up, 0 = count down; sampled on each tick.
- load  input  1  synchronous parallel load strobe.
- load_val  input  4*DIGITS  BCD load value; digit 0 is bits [3:0].
- count  output  4*DIGITS  current BCD value; digit 0 is least significant.
- wrap  output  1  one-clk pulse on wrap-around.
- position  output  DIGITS  active-low digit select; exactly one bit is 0.
- pattern  output  8  active-low segments, bit order {a,b,c,d,e,f,g,dp}.

Behaviour:
- Reset (rst=1 at a clk edge) overrides everything. After reset:
  - count=0, wrap=0, tick divider=0, scan divider=0, scan index=0.
  - position has only bit 0 low; pattern=8'b0000_0011 (the glyph for "0").
- Tick divider:
  - If en=1, it increments each clk; at TICK_DIV-1 it returns to 0 and raises an internal tick for that cycle.
  - If en=0, it holds its value and no tick is raised.
- Counter priority, highest first: rst, load, tick, hold.
- load=1 (regardless of en):
  - count<=load_val next edge.
  - Tick divider clears to 0; wrap=0.
  - A coincident tick is discarded.
- Digit values are not range-checked. A load_val digit of 10..15 is stored as-is, renders as blank, and is treated as 9 by the next count step.
- Tick with up_dn=1 (BCD increment):
  - Digit 0 +1.
  - A digit at 9 becomes 0 and carries into the next digit.
  - All digits at 9 -> all 0, with wrap=1 for exactly one cycle.
- Tick with up_dn=0 (BCD decrement):
  - Digit 0 -1.
  - A digit at 0 becomes 9 and borrows from the next digit.
  - All digits 0 -> all 9, with wrap=1 for exactly one cycle.
- count latency: the new value appears on the clk edge that ends the tick cycle (registered output).
- wrap is registered, asserted in the same cycle the wrapped count first appears, and 0 in every other cycle.
- Scan divider:
  - Free-runs regardless of en.
  - At SCAN_DIV-1 it returns to 0 and the scan index advances: 0,1,..,DIGITS-1,0.
  - If DIGITS=1, the index stays 0.
- position and pattern are registered, updated every clk from the scan index and the registered count:
  - position = ~(1 << index).
  - pattern = glyph of count digit[index].
  - Display lags count by one clk.
- Glyphs (active low, dp always 1):
  - 0=0000_0011, 1=1001_1111, 2=0010_0101, 3=0000_1101, 4=1001_1001
  - 5=0100_1001, 6=0100_0001, 7=0001_1111, 8=0000_0001, 9=0000_1001
  - 10..15=1111_1111 (blank)
- up_dn may change at any time; only its value in the tick cycle matters.
- rst mid-count or mid-scan returns everything to reset values on the same edge.

Test Plan (DIGITS=4, TICK_DIV=4, SCAN_DIV=2):
- Reset, then en=1, up_dn=1 for 40 clk -> count steps 0000,0001,.. every 4 clk; 0009->0010 carry correct; wrap stays 0.
- load=1, load_val=9999, then up_dn=1, one tick -> count=0000; wrap=1 for exactly one clk, coincident with 0000.
- load 0000, up_dn=0, one tick -> count=9999 with wrap pulse. Next tick -> 9998.
- load 0100, up_dn=0, one tick -> 0099 (borrow across two digits). Then en=0 for 20 clk -> count holds 0099, and position still cycles 1110,1101,1011,0111 every 2 clk.
- count=1234 -> when position=1110, pattern=1001_1001 (4). When position=0111, pattern=1001_1111 (1).
- Assert rst for one clk mid-tick with count=5678 -> next cycle count=0000, position=1110, pattern=0000_0011, wrap=0. First tick arrives 4 clk after rst drops.

Source files
------------

// File: rtl/bcd_multi_counter_ssd.sv
// ---------------------------------------------------------------------------
// bcd_multi_counter_ssd
//
// Multi-digit BCD up/down counter driving a time-multiplexed, active-low
// seven-segment display. The system clock is divided internally into a count
// tick (TICK_DIV cycles) and a digit-scan tick (SCAN_DIV cycles).
//
// Ports:
//   clk       system clock, all state changes on its rising edge
//   rst       synchronous reset, active-high
//   en        1 = tick divider runs and counter counts, 0 = both hold
//   up_dn     1 = count up, 0 = count down (sampled in the tick cycle)
//   load      synchronous parallel load strobe (works regardless of en)
//   load_val  BCD load value, digit 0 in bits [3:0]
//   count     current BCD value, digit 0 least significant
//   wrap      one-cycle pulse coincident with the wrapped count value
//   position  active-low digit select, exactly one bit low
//   pattern   active-low segments {a,b,c,d,e,f,g,dp}
// ---------------------------------------------------------------------------
module bcd_multi_counter_ssd #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 100000000,
    parameter int SCAN_DIV = 100000,
    parameter int CNT_W    = 30
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  wrap,
    output logic [DIGITS-1:0]     position,
    output logic [7:0]            pattern
);

    localparam int                IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]  SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    tick_cnt;
    logic [CNT_W-1:0]    scan_cnt;
    logic [IDX_W-1:0]    scan_idx;
    logic                tick;

    logic [4*DIGITS-1:0] next_count;
    logic                next_wrap;
    logic                carry;
    logic [3:0]          digit;

    logic [3:0]          cur_digit;
    logic [DIGITS-1:0]   pos_next;
    logic [7:0]          glyph;

    assign tick = en && (tick_cnt == TICK_LAST);

    // Ripple increment/decrement across the digits. The carry (or borrow)
    // starts at 1 into digit 0 and only survives a digit sitting at its
    // boundary, so a carry out of the top digit means every digit wrapped.
    // Out-of-range digits (10..15) behave as 9 when they take part in a step;
    // digits above where the carry stops are left untouched.
    always_comb begin
        next_count = count;
        carry      = 1'b1;
        digit      = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            digit = count[4*i +: 4];
            if (digit > 4'd9) begin
                digit = 4'd9;
            end
            if (carry) begin
                if (up_dn) begin
                    if (digit == 4'd9) begin
                        next_count[4*i +: 4] = 4'd0;
                    end else begin
                        next_count[4*i +: 4] = digit + 4'd1;
                        carry                = 1'b0;
                    end
                end else begin
                    if (digit == 4'd0) begin
                        next_count[4*i +: 4] = 4'd9;
                    end else begin
                        next_count[4*i +: 4] = digit - 4'd1;
                        carry                = 1'b0;
                    end
                end
            end
        end
        next_wrap = carry;
    end

    // Counter and tick divider. Load beats the tick and restarts the
    // divider, so a full TICK_DIV period follows every load.
    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            wrap     <= 1'b0;
            tick_cnt <= '0;
        end else if (load) begin
            count    <= load_val;
            wrap     <= 1'b0;
            tick_cnt <= '0;
        end else begin
            wrap <= 1'b0;
            if (en) begin
                if (tick) begin
                    tick_cnt <= '0;
                    count    <= next_count;
                    wrap     <= next_wrap;
                end else begin
                    tick_cnt <= tick_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Scan divider free-runs independent of en so the display keeps
    // refreshing while the count is frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IDX_W'(1);
        end else begin
            scan_cnt <= scan_cnt + CNT_W'(1);
        end
    end

    // Select the digit under the scan index and its active-low enable.
    always_comb begin
        cur_digit = 4'd0;
        pos_next  = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (scan_idx == IDX_W'(i)) begin
                cur_digit   = count[4*i +: 4];
                pos_next[i] = 1'b0;
            end
        end
    end

    // Active-low glyph table, decimal point always off; 10..15 are blank.
    always_comb begin
        case (cur_digit)
            4'd0:    glyph = 8'b0000_0011;
            4'd1:    glyph = 8'b1001_1111;
            4'd2:    glyph = 8'b0010_0101;
            4'd3:    glyph = 8'b0000_1101;
            4'd4:    glyph = 8'b1001_1001;
            4'd5:    glyph = 8'b0100_1001;
            4'd6:    glyph = 8'b0100_0001;
            4'd7:    glyph = 8'b0001_1111;
            4'd8:    glyph = 8'b0000_0001;
            4'd9:    glyph = 8'b0000_1001;
            default: glyph = 8'b1111_1111;
        endcase
    end

    // Display outputs are registered, so they trail count by one clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            position <= ~DIGITS'(1);
            pattern  <= 8'b0000_0011;
        end else begin
            position <= pos_next;
            pattern  <= glyph;
        end
    end

endmodule

// File: tb/tb_bcd_multi_counter_ssd.sv
// ---------------------------------------------------------------------------
// tb_bcd_multi_counter_ssd
//
// Directed bench for bcd_multi_counter_ssd with DIGITS=4, TICK_DIV=4 and
// SCAN_DIV=2. Each test task drives its scenario and checks the outputs one
// time unit after the rising edge against hand-derived values.
// ---------------------------------------------------------------------------
module tb_bcd_multi_counter_ssd;

    localparam int DIGITS   = 4;
    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 2;
    localparam int CNT_W    = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        up_dn;
    logic        load;
    logic [15:0] load_val;
    logic [15:0] count;
    logic        wrap;
    logic [3:0]  position;
    logic [7:0]  pattern;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    bcd_multi_counter_ssd #(
        .DIGITS   (DIGITS),
        .TICK_DIV (TICK_DIV),
        .SCAN_DIV (SCAN_DIV),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .wrap     (wrap),
        .position (position),
        .pattern  (pattern)
    );

    always #5 clk = ~clk;

    // One rising edge, then settle; cyc counts edges since the last reset.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [15:0] to_bcd(int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] seg(logic [3:0] d);
        case (d)
            4'd0:    return 8'b0000_0011;
            4'd1:    return 8'b1001_1111;
            4'd2:    return 8'b0010_0101;
            4'd3:    return 8'b0000_1101;
            4'd4:    return 8'b1001_1001;
            4'd5:    return 8'b0100_1001;
            4'd6:    return 8'b0100_0001;
            4'd7:    return 8'b0001_1111;
            4'd8:    return 8'b0000_0001;
            4'd9:    return 8'b0000_1001;
            default: return 8'b1111_1111;
        endcase
    endfunction

    // Scan index seen by the display register at edge n is the index held
    // after edge n-1, which advances every SCAN_DIV edges.
    function automatic int scan_at(int n);
        if (n == 0) return 0;
        return ((n - 1) / SCAN_DIV) % DIGITS;
    endfunction

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; up_dn = 1'b0; load = 1'b0; load_val = 16'h0000;
        step();
        cyc = 0;
        checks++;
        if (count !== 16'h0000) begin
            fails++; $display("[TB] FAIL reset_count: got %h expected 0000", count);
        end
        checks++;
        if (wrap !== 1'b0) begin
            fails++; $display("[TB] FAIL reset_wrap: got %b expected 0", wrap);
        end
        checks++;
        if (position !== 4'b1110) begin
            fails++; $display("[TB] FAIL reset_position: got %b expected 1110", position);
        end
        checks++;
        if (pattern !== 8'b0000_0011) begin
            fails++; $display("[TB] FAIL reset_pattern: got %b expected 00000011", pattern);
        end
    endtask

    task automatic test_count_up();
        logic [15:0] exp_cnt;
        rst = 1'b0; en = 1'b1; up_dn = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            exp_cnt = to_bcd(k / TICK_DIV);
            checks++;
            if (count !== exp_cnt) begin
                fails++; $display("[TB] FAIL up_count k=%0d: got %h expected %h", k, count, exp_cnt);
            end
            checks++;
            if (wrap !== 1'b0) begin
                fails++; $display("[TB] FAIL up_wrap k=%0d: got %b expected 0", k, wrap);
            end
        end
    endtask

    task automatic test_wrap_up();
        load = 1'b1; load_val = 16'h9999; up_dn = 1'b1; en = 1'b1;
        step();
        load = 1'b0;
        checks++;
        if (count !== 16'h9999) begin
            fails++; $display("[TB] FAIL wrapup_load: got %h expected 9999", count);
        end
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++;
            if (count !== ((k < 4) ? 16'h9999 : 16'h0000)) begin
                fails++; $display("[TB] FAIL wrapup_count k=%0d: got %h", k, count);
            end
            checks++;
            if (wrap !== (k == 4)) begin
                fails++; $display("[TB] FAIL wrapup_wrap k=%0d: got %b expected %b", k, wrap, (k == 4));
            end
        end
    endtask

    task automatic test_wrap_down();
        load = 1'b1; load_val = 16'h0000;
        step();
        load = 1'b0; up_dn = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++;
            if (count !== ((k < 4) ? 16'h0000 : 16'h9999)) begin
                fails++; $display("[TB] FAIL wrapdn_count k=%0d: got %h", k, count);
            end
            checks++;
            if (wrap !== (k == 4)) begin
                fails++; $display("[TB] FAIL wrapdn_wrap k=%0d: got %b expected %b", k, wrap, (k == 4));
            end
        end
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++;
            if (count !== ((k < 4) ? 16'h9999 : 16'h9998)) begin
                fails++; $display("[TB] FAIL wrapdn_next k=%0d: got %h", k, count);
            end
            checks++;
            if (wrap !== 1'b0) begin
                fails++; $display("[TB] FAIL wrapdn_nowrap k=%0d: got %b expected 0", k, wrap);
            end
        end
    endtask

    task automatic test_borrow_hold();
        logic [15:0] val;
        logic [3:0]  exp_pos;
        logic [7:0]  exp_pat;
        int          idx;
        load = 1'b1; load_val = 16'h0100; en = 1'b1;
        step();
        load = 1'b0; up_dn = 1'b0;
        for (int k = 1; k <= 4; k++) step();
        checks++;
        if (count !== 16'h0099) begin
            fails++; $display("[TB] FAIL borrow_count: got %h expected 0099", count);
        end
        en = 1'b0;
        val = 16'h0099;
        for (int k = 1; k <= 20; k++) begin
            step();
            idx     = scan_at(cyc);
            exp_pos = ~(4'b0001 << idx);
            exp_pat = seg(val[4*idx +: 4]);
            checks++;
            if (count !== 16'h0099) begin
                fails++; $display("[TB] FAIL hold_count k=%0d: got %h expected 0099", k, count);
            end
            checks++;
            if (position !== exp_pos) begin
                fails++; $display("[TB] FAIL hold_position k=%0d: got %b expected %b", k, position, exp_pos);
            end
            checks++;
            if (pattern !== exp_pat) begin
                fails++; $display("[TB] FAIL hold_pattern k=%0d: got %b expected %b", k, pattern, exp_pat);
            end
        end
    endtask

    task automatic test_display_digits();
        logic [15:0] val;
        logic [3:0]  exp_pos;
        logic [7:0]  exp_pat;
        int          idx;
        en = 1'b0;
        load = 1'b1; load_val = 16'h1234;
        step();
        load = 1'b0;
        val = 16'h1234;
        for (int k = 1; k <= 8; k++) begin
            step();
            idx     = scan_at(cyc);
            exp_pos = ~(4'b0001 << idx);
            exp_pat = seg(val[4*idx +: 4]);
            checks++;
            if (position !== exp_pos) begin
                fails++; $display("[TB] FAIL disp_position k=%0d: got %b expected %b", k, position, exp_pos);
            end
            checks++;
            if (pattern !== exp_pat) begin
                fails++; $display("[TB] FAIL disp_pattern k=%0d: got %b expected %b", k, pattern, exp_pat);
            end
        end
    endtask

    task automatic test_reset_mid();
        en = 1'b1; up_dn = 1'b1;
        load = 1'b1; load_val = 16'h5678;
        step();
        load = 1'b0;
        for (int k = 1; k <= 3; k++) step();
        // Divider now sits at its last count; the load must swallow the tick.
        load = 1'b1; load_val = 16'h5678;
        step();
        load = 1'b0;
        checks++;
        if (count !== 16'h5678) begin
            fails++; $display("[TB] FAIL load_over_tick: got %h expected 5678", count);
        end
        step();
        step();
        rst = 1'b1;
        step();
        cyc = 0;
        checks++;
        if (count !== 16'h0000) begin
            fails++; $display("[TB] FAIL midrst_count: got %h expected 0000", count);
        end
        checks++;
        if (position !== 4'b1110) begin
            fails++; $display("[TB] FAIL midrst_position: got %b expected 1110", position);
        end
        checks++;
        if (pattern !== 8'b0000_0011) begin
            fails++; $display("[TB] FAIL midrst_pattern: got %b expected 00000011", pattern);
        end
        checks++;
        if (wrap !== 1'b0) begin
            fails++; $display("[TB] FAIL midrst_wrap: got %b expected 0", wrap);
        end
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++;
            if (count !== ((k < 4) ? 16'h0000 : 16'h0001)) begin
                fails++; $display("[TB] FAIL midrst_tick k=%0d: got %h", k, count);
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up_dn = 1'b0; load = 1'b0; load_val = 16'h0000;
        $display("[TB] starting");
        test_reset();
        test_count_up();
        test_wrap_up();
        test_wrap_down();
        test_borrow_hold();
        test_display_digits();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
